trashbin_load_store_unit: RTL and testbench

//  Parametrised multi-cycle load/store engine that the core hands every memory-data access to.

---
 rtl/trashbin_load_store_unit_if.sv | 44 ++++
 rtl/trashbin_load_store_unit.sv | 147 ++++++++++++++
 tb/tb_trashbin_load_store_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/trashbin_load_store_unit_if.sv
// Core/memory bundle for the load/store unit.
// master = the LSU itself, slave = core plus memory side.
interface trashbin_load_store_unit_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
) ();
  logic                  Start;
  logic                  IsWrite;
  logic [1:0]            AccessWidth;
  logic                  SignExtend;
  logic [ADDR_WIDTH-1:0] Address;
  logic [XLEN-1:0]       StoreData;
  logic                  Busy;
  logic                  Done;
  logic [XLEN-1:0]       LoadData;
  logic                  Misaligned;
  logic                  Timeout;
  logic [ADDR_WIDTH-1:0] MemAddress;
  logic [XLEN-1:0]       MemWriteData;
  logic [XLEN/8-1:0]     MemByteEnable;
  logic                  MemReadAssert;
  logic                  MemWriteAssert;
  logic [XLEN-1:0]       MemReadData;
  logic                  MemReadOK;
  logic                  MemWriteOK;

  modport master (
    input  Start, IsWrite, AccessWidth, SignExtend,
    input  Address, StoreData,
    input  MemReadData, MemReadOK, MemWriteOK,
    output Busy, Done, LoadData, Misaligned, Timeout,
    output MemAddress, MemWriteData, MemByteEnable,
    output MemReadAssert, MemWriteAssert
  );

  modport slave (
    output Start, IsWrite, AccessWidth, SignExtend,
    output Address, StoreData,
    output MemReadData, MemReadOK, MemWriteOK,
    input  Busy, Done, LoadData, Misaligned, Timeout,
    input  MemAddress, MemWriteData, MemByteEnable,
    input  MemReadAssert, MemWriteAssert
  );
endinterface

// File: rtl/trashbin_load_store_unit.sv
// Multi-cycle load/store engine: lane steering, extension,
// ack wait with timeout, misalign/timeout fault reporting.
module trashbin_load_store_unit #(
  parameter int XLEN           = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic CoreClock,
  input logic CoreReset,
  trashbin_load_store_unit_if.master bus
);
  localparam int NB = XLEN / 8;
  localparam int L  = $clog2(NB);
  localparam int CW = (TIMEOUT_CYCLES > 0) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ?
    TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         count;
  logic                  isWriteQ;
  logic [1:0]            widthQ;
  logic                  signQ;
  logic [ADDR_WIDTH-1:0] addrQ;
  logic [XLEN-1:0]       storeQ;
  logic                  misQ;
  logic                  toQ;
  logic [XLEN-1:0]       loadQ;

  function automatic logic [7:0] laneMask(input logic [1:0] w);
    unique case (w)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  logic [7:0] reqLane;
  logic [7:0] alignMask;
  logic       illegal;

  always_comb begin
    reqLane   = 8'(bus.Address[L-1:0]);
    alignMask = (8'd1 << bus.AccessWidth) - 8'd1;
    illegal   = (|(reqLane & alignMask)) ||
                (XLEN == 32 && bus.AccessWidth == 2'd3);
  end

  logic [L-1:0]    lane;
  logic [L+2:0]    shAmt;
  logic [7:0]      be8;
  logic [NB-1:0]   beBase;
  logic [XLEN-1:0] dataMask;
  logic [XLEN-1:0] shifted;
  logic            msb;
  logic [XLEN-1:0] extended;
  logic            busy;
  logic            ack;

  always_comb begin
    lane   = addrQ[L-1:0];
    shAmt  = {lane, 3'b000};
    be8    = laneMask(widthQ);
    beBase = be8[NB-1:0];
    for (int i = 0; i < NB; i++) begin
      dataMask[8*i +: 8] = {8{beBase[i]}};
    end
    shifted = bus.MemReadData >> shAmt;
    unique case (widthQ)
      2'd0:    msb = shifted[7];
      2'd1:    msb = shifted[15];
      2'd2:    msb = shifted[31];
      default: msb = shifted[XLEN-1];
    endcase
    // sign fill lands on every bit above the access size
    extended = (shifted & dataMask) |
               ((signQ & msb) ? ~dataMask : '0);
    busy = (state == ACCESS);
    ack  = isWriteQ ? bus.MemWriteOK : bus.MemReadOK;
  end

  assign bus.Busy           = busy;
  assign bus.Done           = (state == FINISH);
  assign bus.Misaligned     = bus.Done & misQ;
  assign bus.Timeout        = bus.Done & toQ;
  assign bus.LoadData       = loadQ;
  assign bus.MemAddress     = {addrQ[ADDR_WIDTH-1:L], {L{1'b0}}};
  assign bus.MemByteEnable  = busy ? (beBase << lane) : '0;
  assign bus.MemWriteData   = (busy & isWriteQ) ?
                              ((storeQ & dataMask) << shAmt) : '0;
  assign bus.MemReadAssert  = busy & ~isWriteQ;
  assign bus.MemWriteAssert = busy & isWriteQ;

  always_ff @(posedge CoreClock) begin
    if (CoreReset) begin
      state    <= IDLE;
      count    <= '0;
      isWriteQ <= 1'b0;
      widthQ   <= 2'd0;
      signQ    <= 1'b0;
      addrQ    <= '0;
      storeQ   <= '0;
      misQ     <= 1'b0;
      toQ      <= 1'b0;
      loadQ    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          misQ <= 1'b0;
          toQ  <= 1'b0;
          if (bus.Start) begin
            isWriteQ <= bus.IsWrite;
            widthQ   <= bus.AccessWidth;
            signQ    <= bus.SignExtend;
            addrQ    <= bus.Address;
            storeQ   <= bus.StoreData;
            if (illegal) begin
              misQ  <= 1'b1;
              state <= FINISH;
            end else begin
              count <= '0;
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (ack) begin
            if (!isWriteQ) loadQ <= extended;
            state <= FINISH;
          end else if (TIMEOUT_CYCLES != 0 && count == LAST) begin
            toQ   <= 1'b1;
            state <= FINISH;
          end else if (TIMEOUT_CYCLES != 0) begin
            count <= count + 1'b1;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trashbin_load_store_unit.sv
// Scoreboard bench for the load/store unit, XLEN=32 (timeout 4)
// and XLEN=64 instances.
module tb_trashbin_load_store_unit;
  logic clk = 1'b0;
  logic rst;
  int   nChecks = 0;
  int   nFails  = 0;

  always #5 clk = ~clk;

  trashbin_load_store_unit_if #(.XLEN(32), .ADDR_WIDTH(32)) a ();
  trashbin_load_store_unit_if #(.XLEN(64), .ADDR_WIDTH(32)) b ();

  trashbin_load_store_unit #(
    .XLEN(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)
  ) dutA (
    .CoreClock(clk),
    .CoreReset(rst),
    .bus(a.master)
  );

  trashbin_load_store_unit #(
    .XLEN(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(255)
  ) dutB (
    .CoreClock(clk),
    .CoreReset(rst),
    .bus(b.master)
  );

  task automatic checkVal(input string tag,
                          input logic [63:0] got,
                          input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] ld;
    logic        mis;
    logic        to;
  } exp_t;

  exp_t sbQ[$];
  exp_t mon;

  always @(negedge clk) begin
    if (!rst) begin
      if (a.Done) begin
        if (sbQ.size() == 0) begin
          checkVal("spurious Done", 1, 0);
        end else begin
          mon = sbQ.pop_front();
          checkVal("LoadData", a.LoadData, mon.ld);
          checkVal("Misaligned", a.Misaligned, mon.mis);
          checkVal("Timeout", a.Timeout, mon.to);
        end
      end else begin
        checkVal("idle flags", {a.Misaligned, a.Timeout}, 0);
      end
    end
  end

  task automatic runA(input logic wr, input logic [1:0] w,
                      input logic sx, input logic [31:0] addr,
                      input logic [31:0] sd, input logic [31:0] rd,
                      input int waits, input logic [31:0] expAddr,
                      input logic [3:0] expBe, input logic [31:0] expWd,
                      input logic [31:0] expLd, input logic expMis,
                      input logic expTo, input bit poke);
    int   edgeN = 0;
    int   busyN = 0;
    int   rdN = 0;
    int   wrN = 0;
    int   expBusy;
    bit   seen = 0;
    logic hit;
    exp_t e;
    e.ld  = expLd;
    e.mis = expMis;
    e.to  = expTo;
    sbQ.push_back(e);
    expBusy = expMis ? 0 : (expTo ? 4 : waits + 1);
    @(posedge clk); #1;
    a.Start = 1'b1;
    a.IsWrite = wr;
    a.AccessWidth = w;
    a.SignExtend = sx;
    a.Address = addr;
    a.StoreData = sd;
    a.MemReadData = rd;
    a.MemReadOK = 1'b0;
    a.MemWriteOK = 1'b0;
    @(posedge clk); #1;
    a.Start = 1'b0;
    while (!seen && edgeN < 40) begin
      if (a.Done) begin
        seen = 1;
      end else begin
        if (a.Busy) begin
          checkVal("MemAddress", a.MemAddress, expAddr);
          checkVal("MemByteEnable", a.MemByteEnable, expBe);
          if (wr) checkVal("MemWriteData", a.MemWriteData, expWd);
          rdN += int'(a.MemReadAssert);
          wrN += int'(a.MemWriteAssert);
          hit = (busyN == waits);
          // the unused ack is held high: it must be ignored
          a.MemReadOK  = wr ? 1'b1 : hit;
          a.MemWriteOK = wr ? hit : 1'b1;
          busyN++;
          if (poke) begin
            a.Start   = (busyN == 1);
            a.Address = (busyN == 1) ? 32'h3FC : addr;
            a.IsWrite = (busyN == 1) ? ~wr : wr;
          end
        end
        @(posedge clk); #1;
        edgeN++;
      end
    end
    a.Start = 1'b0;
    a.MemReadOK = 1'b0;
    a.MemWriteOK = 1'b0;
    a.Address = addr;
    a.IsWrite = wr;
    checkVal("Done seen", seen, 1);
    checkVal("Done edge", edgeN + 1,
             expMis ? 1 : (expTo ? 5 : waits + 2));
    checkVal("read cycles", rdN, wr ? 0 : expBusy);
    checkVal("write cycles", wrN, wr ? expBusy : 0);
  endtask

  task automatic runB(input logic [1:0] w, input logic sx,
                      input logic [31:0] addr, input logic [63:0] rd,
                      input logic [31:0] expAddr, input logic [7:0] expBe,
                      input logic [63:0] expLd);
    @(posedge clk); #1;
    b.Start = 1'b1;
    b.IsWrite = 1'b0;
    b.AccessWidth = w;
    b.SignExtend = sx;
    b.Address = addr;
    b.MemReadData = rd;
    b.MemReadOK = 1'b1;
    @(posedge clk); #1;
    b.Start = 1'b0;
    checkVal("B Busy", b.Busy, 1);
    checkVal("B MemAddress", b.MemAddress, expAddr);
    checkVal("B MemByteEnable", b.MemByteEnable, expBe);
    @(posedge clk); #1;
    checkVal("B Done", b.Done, 1);
    checkVal("B LoadData", b.LoadData, expLd);
    b.MemReadOK = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a.Start = 0; a.IsWrite = 0; a.AccessWidth = 0; a.SignExtend = 0;
    a.Address = 0; a.StoreData = 0; a.MemReadData = 0;
    a.MemReadOK = 0; a.MemWriteOK = 0;
    b.Start = 0; b.IsWrite = 0; b.AccessWidth = 0; b.SignExtend = 0;
    b.Address = 0; b.StoreData = 0; b.MemReadData = 0;
    b.MemReadOK = 0; b.MemWriteOK = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkVal("reset Busy", a.Busy, 0);
    checkVal("reset Done", a.Done, 0);
    checkVal("reset LoadData", a.LoadData, 0);
    checkVal("reset asserts", {a.MemReadAssert, a.MemWriteAssert}, 0);
    checkVal("reset MemAddress", a.MemAddress, 0);
    checkVal("reset MemByteEnable", a.MemByteEnable, 0);
    checkVal("reset B LoadData", b.LoadData, 0);

    runA(1, 2'd0, 0, 32'h103, 32'h123456A5, 0, 0,
         32'h100, 4'b1000, 32'hA5000000, 0, 0, 0, 0);
    runA(0, 2'd1, 1, 32'h202, 0, 32'h80011234, 3,
         32'h200, 4'b1100, 0, 32'hFFFF8001, 0, 0, 0);
    runA(0, 2'd0, 0, 32'h005, 0, 32'h0000F000, 1,
         32'h004, 4'b0010, 0, 32'h000000F0, 0, 0, 0);
    runA(0, 2'd2, 0, 32'h006, 0, 32'hFFFFFFFF, 0,
         0, 0, 0, 32'h000000F0, 1, 0, 0);
    runA(0, 2'd3, 0, 32'h008, 0, 32'hFFFFFFFF, 0,
         0, 0, 0, 32'h000000F0, 1, 0, 0);
    runA(0, 2'd1, 0, 32'h003, 0, 32'hFFFFFFFF, 0,
         0, 0, 0, 32'h000000F0, 1, 0, 0);
    runA(0, 2'd2, 0, 32'h010, 0, 32'hDEADBEEF, -1,
         32'h010, 4'b1111, 0, 32'h000000F0, 0, 1, 0);
    runA(1, 2'd1, 0, 32'h00A, 32'hCAFE7777, 0, 2,
         32'h008, 4'b1100, 32'h77770000, 32'h000000F0, 0, 0, 1);
    runA(0, 2'd0, 1, 32'h007, 0, 32'h7F000000, 0,
         32'h004, 4'b1000, 0, 32'h0000007F, 0, 0, 0);
    runA(0, 2'd0, 1, 32'h004, 0, 32'h00000080, 0,
         32'h004, 4'b0001, 0, 32'hFFFFFF80, 0, 0, 0);
    runA(0, 2'd2, 1, 32'h00C, 0, 32'h80000001, 0,
         32'h00C, 4'b1111, 0, 32'h80000001, 0, 0, 0);
    runA(1, 2'd2, 0, 32'h010, 32'hCAFEBABE, 0, 1,
         32'h010, 4'b1111, 32'hCAFEBABE, 32'h80000001, 0, 0, 0);

    // abort a load in its second ACCESS cycle
    @(posedge clk); #1;
    a.Start = 1'b1; a.IsWrite = 1'b0; a.AccessWidth = 2'd2;
    a.Address = 32'h20; a.MemReadOK = 1'b0; a.MemWriteOK = 1'b1;
    @(posedge clk); #1;
    a.Start = 1'b0;
    checkVal("abort Busy before", a.Busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    a.Start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    a.Start = 1'b0;
    a.MemWriteOK = 1'b0;
    checkVal("abort ReadAssert", a.MemReadAssert, 0);
    checkVal("abort Busy", a.Busy, 0);
    checkVal("abort Done", a.Done, 0);
    checkVal("abort LoadData", a.LoadData, 0);
    repeat (3) begin
      @(posedge clk); #1;
      checkVal("post-reset Busy", a.Busy, 0);
    end

    runB(2'd3, 0, 32'h008, 64'h8877665544332211,
         32'h008, 8'hFF, 64'h8877665544332211);
    runB(2'd2, 1, 32'h00C, 64'h80000000_00000000,
         32'h008, 8'hF0, 64'hFFFFFFFF_80000000);
    runB(2'd1, 0, 32'h00E, 64'hBEEF0000_00000000,
         32'h008, 8'hC0, 64'h00000000_0000BEEF);

    repeat (2) @(posedge clk);
    checkVal("scoreboard drained", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end
endmodule
